// File: rtl/cpu_pkg.sv
// Shared constants for the RISC-V core front end.
package cpu_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam int          PC_STEP   = 4;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head word (rdata) that holds its last
// value while the FIFO is empty. clear empties it without touching rdata.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int             AW       = $clog2(DEPTH);
  localparam int             CW       = AW + 1;
  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    next_rd_s;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    next_cnt_s;
  logic [WIDTH-1:0] rdata_r;
  logic [WIDTH-1:0] head_s;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Next head: the word being written becomes head only when no older entry survives.
  always_comb begin
    push_ok_s  = push && (count_r != FULL_CNT);
    pop_ok_s   = pop && (count_r != {CW{1'b0}});
    next_rd_s  = rd_ptr_r + AW'(pop_ok_s);
    next_cnt_s = count_r + CW'(push_ok_s) - CW'(pop_ok_s);
    if (push_ok_s && (wr_ptr_r == next_rd_s)) begin
      head_s = wdata;
    end else begin
      head_s = mem_r[next_rd_s];
    end
  end

  // Storage array write.
  always_ff @(posedge clk) begin
    if (push_ok_s && !clear) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers, occupancy and registered head.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      rdata_r  <= {WIDTH{1'b0}};
    end else if (clear) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      wr_ptr_r <= wr_ptr_r + AW'(push_ok_s);
      rd_ptr_r <= next_rd_s;
      count_r  <= next_cnt_s;
      if (next_cnt_s != {CW{1'b0}}) begin
        rdata_r <= head_s;
      end
    end
  end

  // Output mapping.
  always_comb begin
    rdata = rdata_r;
    count = count_r;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: credit-limited in-order requests to a
// variable-latency memory, a DEPTH-entry instruction queue and redirect flush.
module fetch_queue #(
  parameter int               XLEN     = cpu_pkg::XLEN,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_ready,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  input  logic             redirect,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             ifid_valid,
  output logic [XLEN-1:0]  ifid_pc,
  output logic [31:0]      ifid_instr,
  input  logic             ifid_ready
);

  import cpu_pkg::*;

  localparam int               CW         = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0]  ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
  localparam logic [XLEN-1:0]  STEP       = XLEN'(PC_STEP);
  localparam logic [CW:0]      DEPTH_W    = (CW+1)'(DEPTH);

  logic [XLEN-1:0]    fetch_pc_r;
  logic [CW-1:0]      outst_r;
  logic [CW-1:0]      discard_r;
  logic [CW-1:0]      cnt_s;
  logic [CW-1:0]      tag_cnt_s;
  logic [CW-1:0]      outst_left_s;
  logic [XLEN-1:0]    tag_pc_s;
  logic [XLEN+31:0]   q_rdata_s;
  logic               credit_s;
  logic               accept_s;
  logic               rsp_s;
  logic               enq_s;
  logic               deq_s;

  // Request credit, handshakes and queue traffic for this cycle.
  always_comb begin
    credit_s     = ({1'b0, cnt_s} + {1'b0, outst_r}) < DEPTH_W;
    imem_req     = credit_s && !redirect && !rst;
    imem_addr    = fetch_pc_r;
    accept_s     = imem_req && imem_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    rsp_s        = imem_rvalid && (outst_r != {CW{1'b0}});
    outst_left_s = outst_r - CW'(rsp_s);
    enq_s        = rsp_s && !redirect && (discard_r == {CW{1'b0}})
                   && (tag_cnt_s != {CW{1'b0}});
    ifid_valid   = (cnt_s != {CW{1'b0}});
    deq_s        = ifid_valid && ifid_ready && !redirect;
    ifid_pc      = q_rdata_s[XLEN+31:32];
    ifid_instr   = q_rdata_s[31:0];
  end

  // Fetch PC plus in-flight and to-be-dropped response counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_r <= RESET_PC;
      outst_r    <= {CW{1'b0}};
      discard_r  <= {CW{1'b0}};
    end else if (redirect) begin
      // Every response still in flight belongs to the abandoned path.
      fetch_pc_r <= redirect_pc & ALIGN_MASK;
      outst_r    <= outst_left_s;
      discard_r  <= outst_left_s;
    end else begin
      if (accept_s) begin
        fetch_pc_r <= fetch_pc_r + STEP;
      end
      outst_r <= outst_r + CW'(accept_s) - CW'(rsp_s);
      if (rsp_s && (discard_r != {CW{1'b0}})) begin
        discard_r <= discard_r - CW'(1'b1);
      end
    end
  end

  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (redirect),
    .push  (accept_s),
    .wdata (fetch_pc_r),
    .pop   (enq_s),
    .rdata (tag_pc_s),
    .count (tag_cnt_s)
  );

  sync_fifo #(
    .WIDTH (XLEN + 32),
    .DEPTH (DEPTH)
  ) u_instr_queue (
    .clk   (clk),
    .rst   (rst),
    .clear (redirect),
    .push  (enq_s),
    .wdata ({tag_pc_s, imem_rdata}),
    .pop   (deq_s),
    .rdata (q_rdata_s),
    .count (cnt_s)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with an in-order variable-latency memory model.
module tb_fetch_queue;

  localparam int          XLEN  = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0100;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        ifid_ready;

  fetch_queue #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .RESET_PC (RPC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ifid_valid  (ifid_valid),
    .ifid_pc     (ifid_pc),
    .ifid_instr  (ifid_instr),
    .ifid_ready  (ifid_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t pend[$];
  int    cyc;
  int    lat;
  int    n_acc;
  int    base;
  int    n_cmp;
  int    n_bad;
  int    n_old;
  bit    seen;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: present the due response, record an accepted request, end at negedge.
  task automatic cycle();
    logic        acc;
    logic [31:0] a;
    if (rst || pend.size() == 0 || pend[0].due > cyc) begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end else begin
      imem_rvalid = 1'b1;
      imem_rdata  = instr_of(pend[0].addr);
    end
    #1;
    acc = imem_req && imem_ready;
    a   = imem_addr;
    @(posedge clk);
    cyc++;
    if (rst) begin
      pend.delete();
    end else begin
      if (imem_rvalid) void'(pend.pop_front());
      if (acc) begin
        pend.push_back('{a, cyc + lat - 1});
        n_acc++;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    redirect = 1'b0;
    cycle();
    check("rst_req",   {63'h0, imem_req},   64'h0);
    check("rst_addr",  {32'h0, imem_addr},  {32'h0, RPC});
    check("rst_valid", {63'h0, ifid_valid}, 64'h0);
    check("rst_pc",    {32'h0, ifid_pc},    64'h0);
    check("rst_instr", {32'h0, ifid_instr}, 64'h0);
    rst  = 1'b0;
    base = n_acc;
    #1;
  endtask

  // Advance until the queue head is valid; old-path PCs (below lo) are counted.
  task automatic wait_first(input logic [31:0] lo, input logic [31:0] exp_pc, input string tag);
    seen  = 1'b0;
    n_old = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      if (ifid_valid) begin
        if (ifid_pc < lo) begin
          n_old++;
        end else begin
          check({tag, "_pc"},    {32'h0, ifid_pc},    {32'h0, exp_pc});
          check({tag, "_instr"}, {32'h0, ifid_instr}, {32'h0, instr_of(exp_pc)});
          seen = 1'b1;
        end
      end
      if (!seen) cycle();
    end
    check({tag, "_seen"}, {63'h0, seen}, 64'h1);
    check({tag, "_old"},  64'(n_old),    64'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    cyc = 0; n_acc = 0; n_cmp = 0; n_bad = 0; base = 0;
    lat = 1; imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect = 1'b0; redirect_pc = 32'h0; ifid_ready = 1'b1; rst = 1'b1;

    // Streaming at one request per cycle, head trails requests by two cycles.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      check("t1_req",  {63'h0, imem_req},  64'h1);
      check("t1_addr", {32'h0, imem_addr}, {32'h0, RPC + 32'(4 * k)});
      if (k >= 2) begin
        check("t1_valid", {63'h0, ifid_valid}, 64'h1);
        check("t1_pc",    {32'h0, ifid_pc},    {32'h0, RPC + 32'(4 * (k - 2))});
        check("t1_instr", {32'h0, ifid_instr}, {32'h0, instr_of(RPC + 32'(4 * (k - 2)))});
      end
      cycle();
    end

    // Stalled consumer: exactly DEPTH requests, then one more per pop.
    ifid_ready = 1'b0;
    do_reset();
    repeat (10) cycle();
    check("t2_acc4",  64'(n_acc - base),    64'd4);
    check("t2_req0",  {63'h0, imem_req},    64'h0);
    check("t2_valid", {63'h0, ifid_valid},  64'h1);
    check("t2_pc0",   {32'h0, ifid_pc},     {32'h0, RPC});
    ifid_ready = 1'b1;
    cycle();
    ifid_ready = 1'b0;
    #1;
    check("t2_pc1",   {32'h0, ifid_pc},     {32'h0, RPC + 32'h4});
    check("t2_req1",  {63'h0, imem_req},    64'h1);
    check("t2_addr1", {32'h0, imem_addr},   {32'h0, RPC + 32'h10});
    repeat (6) cycle();
    check("t2_acc5",  64'(n_acc - base),    64'd5);
    check("t2_req2",  {63'h0, imem_req},    64'h0);

    // Redirect with three responses in flight (latency 4).
    lat = 4; ifid_ready = 1'b1;
    do_reset();
    repeat (3) cycle();
    check("t3_acc3",  64'(n_acc - base),    64'd3);
    check("t3_valid", {63'h0, ifid_valid},  64'h0);
    redirect = 1'b1; redirect_pc = 32'h0000_2002;
    #1;
    check("t3_req_rd", {63'h0, imem_req},   64'h0);
    cycle();
    redirect = 1'b0;
    #1;
    check("t3_valid1", {63'h0, ifid_valid}, 64'h0);
    check("t3_req",    {63'h0, imem_req},   64'h1);
    check("t3_addr",   {32'h0, imem_addr},  64'h2000);
    wait_first(32'h0000_2000, 32'h0000_2000, "t3_first");

    // Redirect coinciding with a response and a pop (latency 3).
    lat = 3; ifid_ready = 1'b1;
    do_reset();
    repeat (4) cycle();
    check("t4_valid", {63'h0, ifid_valid}, 64'h1);
    check("t4_pc",    {32'h0, ifid_pc},    {32'h0, RPC});
    redirect = 1'b1; redirect_pc = 32'h0000_3001;
    #1;
    check("t4_req_rd", {63'h0, imem_req},  64'h0);
    cycle();
    redirect = 1'b0;
    #1;
    check("t4_valid1", {63'h0, ifid_valid}, 64'h0);
    check("t4_req",    {63'h0, imem_req},   64'h1);
    check("t4_addr",   {32'h0, imem_addr},  64'h3000);
    wait_first(32'h0000_3000, 32'h0000_3000, "t4_first");

    // Fetch address wraps at the top of the address space.
    lat = 1; ifid_ready = 1'b1;
    do_reset();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    #1;
    check("t5_req_rd", {63'h0, imem_req},  64'h0);
    cycle();
    redirect = 1'b0;
    #1;
    check("t5_req0",  {63'h0, imem_req},  64'h1);
    check("t5_addr0", {32'h0, imem_addr}, 64'hFFFF_FFFC);
    cycle();
    check("t5_req1",  {63'h0, imem_req},  64'h1);
    check("t5_addr1", {32'h0, imem_addr}, 64'h0);
    cycle();
    check("t5_pc0",    {32'h0, ifid_pc},    64'hFFFF_FFFC);
    check("t5_instr0", {32'h0, ifid_instr}, {32'h0, instr_of(32'hFFFF_FFFC)});
    cycle();
    check("t5_pc1",    {32'h0, ifid_pc},    64'h0);
    check("t5_instr1", {32'h0, ifid_instr}, {32'h0, instr_of(32'h0)});

    // Reset with entries queued and responses outstanding.
    lat = 3; ifid_ready = 1'b0;
    do_reset();
    repeat (5) cycle();
    check("t6_acc",   64'(n_acc - base),   64'd4);
    check("t6_valid", {63'h0, ifid_valid}, 64'h1);
    do_reset();
    check("t6_req",  {63'h0, imem_req},  64'h1);
    check("t6_addr", {32'h0, imem_addr}, {32'h0, RPC});
    ifid_ready = 1'b1;
    wait_first(RPC, RPC, "t6_first");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
